// File: rtl/sha256_pkg.sv
// Shared widths, pad constant and state encoding for the SHA-256 message padder.
package sha256_pkg;
  localparam int WORD_W = 32;
  localparam int BLK_W  = 512;
  localparam int LEN_W  = 64;
  localparam int NSLOT  = BLK_W / WORD_W;

  localparam logic [WORD_W-1:0] PAD_WORD = 32'h8000_0000;

  typedef enum logic [1:0] {
    ABSORB    = 2'd0,
    EMIT      = 2'd1,
    EXTRA     = 2'd2,
    EMIT_LAST = 2'd3
  } state_t;
endpackage

// File: rtl/sha256_pad_word.sv
// Final-beat word shaping: keep nbytes bytes, insert 0x80 after them, zero the rest.
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] data,
  input  logic [2:0]        nbytes,
  output logic [WORD_W-1:0] word
);
  always_comb begin
    word = '0;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < nbytes)
        word[31-8*b -: 8] = data[31-8*b -: 8];
      else if (3'(b) == nbytes)
        word[31-8*b -: 8] = 8'h80;
    end
  end
endmodule

// File: rtl/sha256_padder.sv
// SHA-256 padder: packs 32-bit beats into 512-bit blocks, appends 0x80, zeros and length.
// Optional SHA256_PADDER_SKID_EN adds an output block buffer so absorption overlaps emission.
module sha256_padder
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  input  logic [2:0]        in_nbytes,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [BLK_W-1:0]  blk_data,
  output logic              blk_first,
  output logic              blk_last
);
  state_t state, state_nxt;

  logic [WORD_W-1:0] slot [NSLOT];
  logic [3:0]        idx;
  logic [LEN_W-1:0]  len, len_nxt;
  logic              first_arm, last_r, extra_pend, pad_pend;
  logic              in_ready_i, form_valid, adv, accept, blk_done, close;
  logic [4:0]        pad_slot;
  logic [5:0]        add_bits;
  logic [WORD_W-1:0] pad_out;
  logic [BLK_W-1:0]  flat;

  sha256_pad_word u_pad (
    .data   (in_data),
    .nbytes (in_nbytes),
    .word   (pad_out)
  );

  assign accept   = in_valid & in_ready_i & ~reset;
  assign blk_done = accept & (in_last | (idx == 4'd15));
  assign add_bits = in_last ? {in_nbytes, 3'b000} : 6'd32;
  assign len_nxt  = len + {58'd0, add_bits};
  // A full final word pushes the 0x80 marker into the following slot.
  assign pad_slot = {1'b0, idx} + {4'd0, (in_last && in_nbytes == 3'd4)};
  assign close    = in_last && (pad_slot <= 5'd13);

  always_ff @(posedge clk) begin
    if (reset) state <= ABSORB;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ABSORB:    if (blk_done) state_nxt = EMIT;
      EMIT:      if (adv) state_nxt = extra_pend ? EXTRA : ABSORB;
      EXTRA:     state_nxt = EMIT_LAST;
      EMIT_LAST: if (adv) state_nxt = ABSORB;
      default:   state_nxt = ABSORB;
    endcase
  end

  always_comb begin
    in_ready_i = (state == ABSORB);
    form_valid = (state == EMIT) || (state == EMIT_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSLOT; i++) slot[i] <= '0;
      idx        <= '0;
      len        <= '0;
      first_arm  <= 1'b1;
      last_r     <= 1'b0;
      extra_pend <= 1'b0;
      pad_pend   <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < NSLOT; i++) begin
          if (4'(i) == idx)
            slot[i] <= in_last ? pad_out : in_data;
          else if (in_last && (4'(i) > idx)) begin
            if (5'(i) == pad_slot)      slot[i] <= PAD_WORD;
            else if (close && i == 14)  slot[i] <= len_nxt[63:32];
            else if (close && i == 15)  slot[i] <= len_nxt[31:0];
            else                        slot[i] <= '0;
          end
        end
        len <= len_nxt;
        idx <= in_last ? 4'd0 : idx + 4'd1;
        if (in_last) begin
          last_r     <= close;
          extra_pend <= ~close;
          pad_pend   <= (pad_slot == 5'd16);
        end else if (idx == 4'd15) begin
          last_r     <= 1'b0;
          extra_pend <= 1'b0;
          pad_pend   <= 1'b0;
        end
      end
      if (state == EXTRA) begin
        slot[0] <= pad_pend ? PAD_WORD : '0;
        for (int i = 1; i < 14; i++) slot[i] <= '0;
        slot[14]   <= len[63:32];
        slot[15]   <= len[31:0];
        last_r     <= 1'b1;
        extra_pend <= 1'b0;
        pad_pend   <= 1'b0;
      end
      if (adv) begin
        first_arm <= last_r;
        if (last_r) len <= '0;
      end
    end
  end

  always_comb begin
    flat = '0;
    for (int i = 0; i < NSLOT; i++) flat[BLK_W-1-WORD_W*i -: WORD_W] = slot[i];
  end

`ifdef SHA256_PADDER_SKID_EN
  logic [BLK_W-1:0] obuf;
  logic             ovalid, ofirst, olast;

  assign adv = form_valid & (~ovalid | blk_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      obuf   <= '0;
      ovalid <= 1'b0;
      ofirst <= 1'b0;
      olast  <= 1'b0;
    end else if (adv) begin
      obuf   <= flat;
      ovalid <= 1'b1;
      ofirst <= first_arm;
      olast  <= last_r;
    end else if (blk_ready) begin
      ovalid <= 1'b0;
    end
  end

  assign in_ready  = ~reset & in_ready_i;
  assign blk_valid = ~reset & ovalid;
  assign blk_data  = reset ? '0 : obuf;
  assign blk_first = blk_valid & ofirst;
  assign blk_last  = blk_valid & olast;
`else
  assign adv       = form_valid & blk_ready;
  assign in_ready  = ~reset & in_ready_i;
  assign blk_valid = ~reset & form_valid;
  assign blk_data  = reset ? '0 : flat;
  assign blk_first = blk_valid & first_arm;
  assign blk_last  = blk_valid & last_r;
`endif
endmodule

// File: tb/tb_sha256_padder.sv
// Directed-vector bench for sha256_padder (default single-buffer build).
module tb_sha256_padder;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic [2:0]   in_nbytes = 3'd4;
  logic         blk_valid;
  logic         blk_ready = 1'b0;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;

  logic [511:0] eb;
  int checks = 0;
  int errors = 0;

  sha256_padder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_nbytes (in_nbytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic setw(input int i, input logic [31:0] v);
    eb[511-32*i -: 32] = v;
  endtask

  task automatic send(input logic [31:0] d, input logic last, input logic [2:0] n);
    int cnt = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = last; in_nbytes = n;
    while (!in_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 50) chk("send_timeout", 512'(in_ready), 512'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0; in_nbytes = 3'd4;
  endtask

  task automatic wait_blk(input string tag);
    int cnt = 0;
    @(negedge clk);
    while (!blk_valid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_valid"}, 512'(blk_valid), 512'(1));
  endtask

  task automatic get_blk(input string tag, input logic f, input logic l);
    wait_blk(tag);
    chk({tag, "_data"},  blk_data, eb);
    chk({tag, "_first"}, 512'(blk_first), 512'(f));
    chk({tag, "_last"},  512'(blk_last), 512'(l));
    blk_ready = 1'b1;
    @(posedge clk);
    #1;
    blk_ready = 1'b0;
  endtask

  initial begin
    // reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  512'(in_ready), 512'(0));
    chk("rst_blk_valid", 512'(blk_valid), 512'(0));
    chk("rst_blk_data",  blk_data, 512'(0));
    chk("rst_blk_first", 512'(blk_first), 512'(0));
    chk("rst_blk_last",  512'(blk_last), 512'(0));
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 512'(in_ready), 512'(1));

    // "abc" with junk in the unused byte
    send(32'h6162_63FF, 1'b1, 3'd3);
    eb = '0; setw(0, 32'h6162_6380); setw(15, 32'h18);
    get_blk("abc", 1'b1, 1'b1);

    // empty message
    send(32'hDEAD_BEEF, 1'b1, 3'd0);
    eb = '0; setw(0, 32'h8000_0000);
    get_blk("empty", 1'b1, 1'b1);

    // 9 bytes: two words plus one byte
    send(32'h0102_0304, 1'b0, 3'd4);
    send(32'h0506_0708, 1'b0, 3'd4);
    send(32'h09AA_BBCC, 1'b1, 3'd1);
    eb = '0; setw(0, 32'h0102_0304); setw(1, 32'h0506_0708);
    setw(2, 32'h0980_0000); setw(15, 32'h48);
    get_blk("b9", 1'b1, 1'b1);

    // 56 bytes: marker word spills into W14, length in an extra block
    eb = '0;
    for (int k = 0; k < 14; k++) begin
      send(32'h1000_0000 + k, (k == 13), 3'd4);
      setw(k, 32'h1000_0000 + k);
    end
    setw(14, 32'h8000_0000);
    get_blk("b56_1", 1'b1, 1'b0);
    eb = '0; setw(15, 32'h1C0);
    get_blk("b56_2", 1'b0, 1'b1);

    // 64 bytes: marker needs slot 16, so it opens the extra block
    eb = '0;
    for (int k = 0; k < 16; k++) begin
      send(32'h2000_0000 + k, (k == 15), 3'd4);
      setw(k, 32'h2000_0000 + k);
    end
    get_blk("b64_1", 1'b1, 1'b0);
    eb = '0; setw(0, 32'h8000_0000); setw(15, 32'h200);
    get_blk("b64_2", 1'b0, 1'b1);

    // 58 bytes: 0x80 byte lands in slot 14
    eb = '0;
    for (int k = 0; k < 14; k++) begin
      send(32'h3000_0000 + k, 1'b0, 3'd4);
      setw(k, 32'h3000_0000 + k);
    end
    send(32'hAABB_CCDD, 1'b1, 3'd2);
    setw(14, 32'hAABB_8000);
    get_blk("b58_1", 1'b1, 1'b0);
    eb = '0; setw(15, 32'h1D0);
    get_blk("b58_2", 1'b0, 1'b1);

    // downstream stall for 5 cycles
    send(32'h6162_6300, 1'b1, 3'd3);
    eb = '0; setw(0, 32'h6162_6380); setw(15, 32'h18);
    wait_blk("stall");
    for (int k = 0; k < 5; k++) begin
      chk("stall_data",     blk_data, eb);
      chk("stall_valid",    512'(blk_valid), 512'(1));
      chk("stall_in_ready", 512'(in_ready), 512'(0));
      @(negedge clk);
    end
    blk_ready = 1'b1;
    @(posedge clk);
    #1;
    blk_ready = 1'b0;
    @(negedge clk);
    chk("stall_done_valid",    512'(blk_valid), 512'(0));
    chk("stall_done_in_ready", 512'(in_ready), 512'(1));

    // reset after 7 words discards the partial message
    for (int k = 0; k < 7; k++) send(32'h4000_0000 + k, 1'b0, 3'd4);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_in_ready", 512'(in_ready), 512'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_release_ready", 512'(in_ready), 512'(1));
    send(32'h6162_6300, 1'b1, 3'd3);
    eb = '0; setw(0, 32'h6162_6380); setw(15, 32'h18);
    get_blk("after_rst", 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
